// File: rtl/logicap_pkg.sv
// Shared types and helpers for the capture DMA writer.
// FSM encoding, AXI response code, status bit positions, burst sizing.
package logicap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int unsigned STATUS_ABORTED   = 0;
  localparam int unsigned STATUS_TRUNCATED = 1;
  localparam int unsigned STATUS_BRESP_ERR = 2;

  function automatic logic [8:0] burst_beats(
    input logic [31:0] remaining,
    input int unsigned max_len
  );
    if (remaining < max_len) return 9'(remaining);
    return 9'(max_len);
  endfunction

endpackage

// File: rtl/capture_dma_writer_if.sv
// Stream-in / AXI write-out bundle of the capture DMA writer.
// master = the writer itself, slave = stream source plus memory.
interface capture_dma_writer_if #(
  parameter int dataw  = 32,
  parameter int addr_w = 32
);
  logic [dataw-1:0]  s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [addr_w-1:0] m_awaddr;
  logic [7:0]        m_awlen;
  logic              m_awvalid;
  logic              m_awready;
  logic [dataw-1:0]  m_wdata;
  logic              m_wvalid;
  logic              m_wready;
  logic              m_wlast;
  logic              m_bvalid;
  logic              m_bready;
  logic [1:0]        m_bresp;

  modport master (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output m_awaddr, m_awlen, m_awvalid,
    input  m_awready,
    output m_wdata, m_wvalid, m_wlast,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  m_awaddr, m_awlen, m_awvalid,
    output m_awready,
    input  m_wdata, m_wvalid, m_wlast,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready
  );
endinterface

// File: rtl/capture_dma_writer.sv
// Streams captured samples into memory as aligned AXI write bursts.
// Early stream end or abort pads the open burst with zeros.
module capture_dma_writer
  import logicap_pkg::*;
#(
  parameter int dataw     = 32,
  parameter int saddr_w   = 24,
  parameter int addr_w    = 32,
  parameter int burst_len = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [dataw-1:0]   s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  input  logic               start,
  input  logic               abort,
  input  logic [addr_w-1:0]  base_addr,
  input  logic [saddr_w-1:0] sample_count,
  output logic               busy,
  output logic               done,
  output logic [2:0]         status,
  output logic [saddr_w-1:0] words_written,
  output logic [addr_w-1:0]  m_awaddr,
  output logic [7:0]         m_awlen,
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic [dataw-1:0]   m_wdata,
  output logic               m_wvalid,
  input  logic               m_wready,
  output logic               m_wlast,
  input  logic               m_bvalid,
  output logic               m_bready,
  input  logic [1:0]         m_bresp
);

  localparam int BEAT_BYTES  = dataw / 8;
  localparam int BURST_BYTES = burst_len * BEAT_BYTES;
  localparam logic [addr_w-1:0] ALIGN_MASK =
    addr_w'(BURST_BYTES - 1);

  state_e             state_q, state_d;
  logic [addr_w-1:0]  addr_q, addr_d;
  logic [saddr_w-1:0] rem_q, rem_d;
  logic [saddr_w-1:0] words_q, words_d;
  logic [8:0]         blen_q, blen_d;
  logic [8:0]         bcnt_q, bcnt_d;
  logic               pad_q, pad_d;
  logic               stop_q, stop_d;
  logic [2:0]         status_q, status_d;

  logic [8:0] next_beats;
  logic       in_data;
  logic       w_valid;
  logic       t_ready;
  logic       w_fire;
  logic       s_fire;
  logic       last_beat;
  logic       aligned;

  assign next_beats = burst_beats(32'(rem_q), burst_len);
  assign in_data    = state_q == ST_DATA;
  assign w_valid    = in_data && (pad_q || s_tvalid);
  assign t_ready    = in_data && !pad_q && m_wready;
  assign w_fire     = w_valid && m_wready;
  assign s_fire     = s_tvalid && t_ready;
  assign last_beat  = bcnt_q == (blen_q - 9'd1);
  assign aligned    = (base_addr & ALIGN_MASK) == '0;

  // Outputs are forced quiet while reset is held, whatever the state.
  assign m_awvalid = resetn && state_q == ST_ADDR;
  assign m_awaddr  = resetn ? addr_q : '0;
  assign m_awlen   = (resetn && state_q == ST_ADDR) ?
                     8'(next_beats - 9'd1) : 8'd0;
  assign m_wvalid  = resetn && w_valid;
  assign m_wdata   = (resetn && in_data && !pad_q) ? s_tdata : '0;
  assign m_wlast   = resetn && in_data && last_beat;
  assign s_tready  = resetn && t_ready;
  assign m_bready  = resetn && state_q == ST_RESP;
  assign busy      = resetn && state_q != ST_IDLE;
  assign done      = resetn && state_q == ST_FIN;
  assign status    = resetn ? status_q : 3'd0;
  assign words_written = resetn ? words_q : '0;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    words_d  = words_q;
    blen_d   = blen_q;
    bcnt_d   = bcnt_q;
    pad_d    = pad_q;
    stop_d   = stop_q;
    status_d = status_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && sample_count != '0 && aligned) begin
          addr_d   = base_addr;
          rem_d    = sample_count;
          words_d  = '0;
          status_d = 3'd0;
          stop_d   = 1'b0;
          pad_d    = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_awready) begin
          blen_d  = next_beats;
          bcnt_d  = 9'd0;
          addr_d  = addr_q + addr_w'(next_beats) *
                    addr_w'(BEAT_BYTES);
          state_d = ST_DATA;
          // Address already accepted: the burst must still be filled.
          if (abort) begin
            status_d[STATUS_ABORTED] = 1'b1;
            stop_d = 1'b1;
            pad_d  = 1'b1;
          end
        end else if (abort) begin
          status_d[STATUS_ABORTED] = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_DATA: begin
        if (abort) begin
          status_d[STATUS_ABORTED] = 1'b1;
          stop_d = 1'b1;
          pad_d  = 1'b1;
        end
        if (s_fire) begin
          words_d = words_q + saddr_w'(1);
          if (s_tlast && rem_q != saddr_w'(1)) begin
            status_d[STATUS_TRUNCATED] = 1'b1;
            stop_d = 1'b1;
            pad_d  = 1'b1;
          end
        end
        if (w_fire) begin
          bcnt_d = bcnt_q + 9'd1;
          rem_d  = rem_q - saddr_w'(1);
          if (last_beat) begin
            pad_d   = 1'b0;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (abort) begin
          status_d[STATUS_ABORTED] = 1'b1;
          stop_d = 1'b1;
        end
        if (m_bvalid) begin
          if (m_bresp != AXI_RESP_OKAY) begin
            status_d[STATUS_BRESP_ERR] = 1'b1;
            stop_d = 1'b1;
          end
          state_d = (rem_q != '0 && !stop_d) ? ST_ADDR : ST_FIN;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      words_q  <= '0;
      blen_q   <= 9'd0;
      bcnt_q   <= 9'd0;
      pad_q    <= 1'b0;
      stop_q   <= 1'b0;
      status_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      words_q  <= words_d;
      blen_q   <= blen_d;
      bcnt_q   <= bcnt_d;
      pad_q    <= pad_d;
      stop_q   <= stop_d;
      status_q <= status_d;
    end
  end

endmodule

// File: doc/capture_dma_writer.md
CAPTURE_DMA_WRITER -- requirements
Module: capture_dma_writer

Interface
REQ-001 SHALL have parameter dataw, default 32: sample/beat width in bits; 32 or 64 only.
REQ-002 SHALL have parameter saddr_w, default 24: width of sample counters.
REQ-003 SHALL have parameter addr_w, default 32: memory byte-address width.
REQ-004 SHALL have parameter burst_len, default 16: maximum beats per burst; a power of 2, from 2 to 256.
REQ-005 SHALL have one clock, clk; reset is resetn, synchronous and active-low.
REQ-006 SHALL provide ports:
- clk  in  1  sole clock
- resetn  in  1  synchronous active-low reset
- s_tdata  in  dataw  sample stream from the FIFO master side
- s_tvalid  in  1
- s_tready  out  1
- s_tlast  in  1
- start  in  1  one-cycle pulse that begins a transfer
- abort  in  1  one-cycle pulse that ends a transfer early
- base_addr  in  addr_w  destination byte address
- sample_count  in  saddr_w  number of beats to write
- busy  out  1
- done  out  1  one-cycle pulse at completion
- status  out  3  {bresp_err, truncated, aborted}
- words_written  out  saddr_w  real (non-pad) beats accepted
- m_awaddr  out  addr_w
- m_awlen  out  8
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  dataw
- m_wvalid  out  1
- m_wready  in  1
- m_wlast  out  1
- m_bvalid  in  1
- m_bready  out  1
- m_bresp  in  2

Function
REQ-007 SHALL implement the FSM states IDLE, ADDR, DATA, RESP and FIN.
REQ-008 In IDLE, start SHALL be accepted only when sample_count != 0 and base_addr is aligned to burst_len*dataw/8. On acceptance it SHALL latch base_addr and sample_count, clear status and words_written, and go to ADDR. Otherwise start SHALL be ignored.
REQ-009 In ADDR, m_awvalid SHALL be high and m_awlen SHALL equal min(burst_len, remaining)-1. m_awaddr and m_awlen SHALL stay stable until the handshake, then the FSM SHALL go to DATA.
REQ-010 In DATA, m_wvalid SHALL equal s_tvalid, s_tready SHALL equal m_wready, and m_wdata SHALL equal s_tdata, all combinationally, with zero-cycle latency.
REQ-011 m_wlast SHALL be asserted on the final beat of each burst. After the last beat handshake the FSM SHALL go to RESP.
REQ-012 In RESP, m_bready SHALL be high.
REQ-013 On a B handshake the FSM SHALL go to ADDR if remaining beats > 0 and no stop condition is set; otherwise it SHALL go to FIN.
REQ-014 FIN SHALL last exactly one cycle, pulse done, and return to IDLE.
REQ-015 After each burst the address SHALL advance by beats*dataw/8, computed modulo 2^addr_w.
REQ-016 If s_tlast is accepted before the final beat of the whole transfer, the block SHALL:
- set truncated;
- complete the current burst with zero-data pad beats (m_wvalid=1, s_tready=0);
- end after that burst's response.
REQ-017 s_tlast on the final beat SHALL be treated as normal completion.
REQ-018 A missing s_tlast on the final beat SHALL NOT be an error.
REQ-019 If abort arrives in IDLE, it SHALL be ignored.
REQ-020 If abort arrives in ADDR before the handshake, the block SHALL go directly to FIN with aborted set.
REQ-021 If abort arrives in DATA, the block SHALL set aborted, pad the rest of the burst with zeros, and then end via RESP.
REQ-022 If abort arrives in RESP, the block SHALL set aborted and end after the response.
REQ-023 An m_bresp value other than 0 SHALL set bresp_err and end the transfer after that response.
REQ-024 If abort and s_tlast occur in the same cycle, both aborted and truncated SHALL be set.
REQ-025 s_tready SHALL be 0 outside DATA and during padding; excess stream beats SHALL remain unconsumed.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 words_written SHALL increment only on real s_tvalid&&s_tready handshakes.

Reset
REQ-028 When resetn=0 at a clk edge, the FSM SHALL go to IDLE from any state, including mid-burst.
REQ-029 During reset, all valid/ready outputs SHALL be 0; busy, done, status and words_written SHALL be 0; m_awaddr, m_awlen and m_wlast SHALL be 0.
REQ-030 An in-flight memory burst SHALL NOT be completed after reset; system-level reset of the slave is assumed to accompany it.

Structure
REQ-031 The shared package logicap_pkg SHALL hold the FSM state enum, the AXI_RESP_OKAY constant and the STATUS bit-index constants.
REQ-032 The block SHALL be a single module with no sub-modules; the burst-length min() function SHALL reside in logicap_pkg.

Verification
REQ-033 base=0x1000, count=40, burst_len=16, all ready=1, stream 0..39 -> AW at 0x1000/len 15, 0x1040/len 15, 0x1080/len 7; data 0..39 in order; done pulses; status=0; words_written=40.
REQ-034 count=40, s_tlast on beat 20 -> second burst carries beats 16..20 followed by 11 zero pads; no third AW; status=truncated; words_written=21.
REQ-035 abort during beat 5 of the first burst -> beats 6..15 are zero pads, one B handshake, done; status=aborted.
REQ-036 m_bresp=2 on the first burst with count=40 -> no second AW; status=bresp_err; done pulses.
REQ-037 Misaligned base=0x1004, or count=0 -> start ignored; busy stays 0; no AW.
REQ-038 resetn=0 mid-DATA with random m_wready/s_tvalid throttling -> next cycle shows IDLE with all outputs 0; a new start afterwards completes normally.
